uart_fifo_bridge: RTL and testbench

Byte-stream buffering stage between the host side (CPU MMIO/console logic) and the UART 8N1 PHY. It provides a TX FIFO that feeds the PHY's `tx_data`/`tx_valid`/`tx_ready` handshake, and an RX FIFO that captures the PHY's single-cycle `rx_ready` strobes. It also reports fill levels, a sticky RX overflow flag and flush controls. Both FIFOs are register-based, share one clock, and add no combinational path from host inputs to PHY outputs.

---
 rtl/uart_fifo_bridge.sv | 113 +++++++++++
 tb/tb_uart_fifo_bridge.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_bridge.sv
// TX and RX byte FIFOs between host console logic and a UART 8N1 PHY.
// The PHY-facing outputs depend only on registers and the arrays.
module uart_fifo_bridge #(
    parameter  int DEPTH = 16,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    host_tx_data,
    input  logic          host_tx_valid,
    output logic          host_tx_ready,
    output logic [7:0]    host_rx_data,
    output logic          host_rx_valid,
    input  logic          host_rx_ready,
    input  logic          tx_flush,
    input  logic          rx_flush,
    input  logic          ovf_clr,
    output logic [LW-1:0] tx_level,
    output logic [LW-1:0] rx_level,
    output logic          rx_overflow,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    input  logic [7:0]    rx_data,
    input  logic          rx_ready
);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_fifo_bridge: DEPTH must be a power of two >= 2");
        end
    endgenerate

    localparam int            AW   = LW - 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    logic [7:0]    tx_mem [DEPTH];
    logic [7:0]    rx_mem [DEPTH];
    logic [LW-1:0] tx_wr_ptr, tx_rd_ptr;
    logic [LW-1:0] rx_wr_ptr, rx_rd_ptr;

    logic tx_push, tx_pop, rx_push, rx_pop, rx_drop;

    assign host_tx_ready = (tx_level != FULL);
    assign tx_valid      = (tx_level != '0);
    assign tx_data       = tx_mem[tx_rd_ptr[AW-1:0]];

    assign host_rx_valid = (rx_level != '0);
    assign host_rx_data  = rx_mem[rx_rd_ptr[AW-1:0]];

    assign tx_push = host_tx_valid && host_tx_ready && !tx_flush;
    assign tx_pop  = tx_valid && tx_ready;

    // A full RX FIFO still accepts a byte when the host frees a slot in the same cycle.
    assign rx_pop  = host_rx_valid && host_rx_ready;
    assign rx_push = rx_ready && !rx_flush && ((rx_level != FULL) || rx_pop);
    assign rx_drop = rx_ready && !rx_flush && (rx_level == FULL) && !rx_pop;

    // NOTE: storage arrays carry no reset; occupancy is tracked by pointers/level,
    // and leaving the arrays unreset lets them map onto plain registers or RAM.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_ptr[AW-1:0]] <= host_tx_data;
        if (rx_push) rx_mem[rx_wr_ptr[AW-1:0]] <= rx_data;
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_level  <= '0;
        end else if (tx_flush) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_level  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + LW'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + LW'(1);
            unique case ({tx_push, tx_pop})
                2'b10:   tx_level <= tx_level + LW'(1);
                2'b01:   tx_level <= tx_level - LW'(1);
                default: tx_level <= tx_level;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_wr_ptr   <= '0;
            rx_rd_ptr   <= '0;
            rx_level    <= '0;
            rx_overflow <= 1'b0;
        end else if (rx_flush) begin
            rx_wr_ptr   <= '0;
            rx_rd_ptr   <= '0;
            rx_level    <= '0;
            rx_overflow <= 1'b0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + LW'(1);
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + LW'(1);
            unique case ({rx_push, rx_pop})
                2'b10:   rx_level <= rx_level + LW'(1);
                2'b01:   rx_level <= rx_level - LW'(1);
                default: rx_level <= rx_level;
            endcase
            // Setting the sticky flag wins over a same-cycle clear.
            if (rx_drop)      rx_overflow <= 1'b1;
            else if (ovf_clr) rx_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Self-checking bench for uart_fifo_bridge: queue-based reference model,
// directed scenarios plus randomized TX/RX traffic.
module tb_uart_fifo_bridge;

    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    host_tx_data;
    logic          host_tx_valid;
    logic          host_tx_ready;
    logic [7:0]    host_rx_data;
    logic          host_rx_valid;
    logic          host_rx_ready;
    logic          tx_flush;
    logic          rx_flush;
    logic          ovf_clr;
    logic [LW-1:0] tx_level;
    logic [LW-1:0] rx_level;
    logic          rx_overflow;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [7:0]    rx_data;
    logic          rx_ready;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] tq[$];
    logic [7:0] rq[$];
    logic       ovf_model;

    uart_fifo_bridge #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .host_tx_data(host_tx_data), .host_tx_valid(host_tx_valid), .host_tx_ready(host_tx_ready),
        .host_rx_data(host_rx_data), .host_rx_valid(host_rx_valid), .host_rx_ready(host_rx_ready),
        .tx_flush(tx_flush), .rx_flush(rx_flush), .ovf_clr(ovf_clr),
        .tx_level(tx_level), .rx_level(rx_level), .rx_overflow(rx_overflow),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_ready(rx_ready)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        host_tx_data = 8'h00; host_tx_valid = 1'b0; host_rx_ready = 1'b0;
        tx_flush = 1'b0; rx_flush = 1'b0; ovf_clr = 1'b0;
        tx_ready = 1'b0; rx_data = 8'h00; rx_ready = 1'b0;
    endtask

    task automatic check_idle_state(input string tag);
        n_cmp++; if (tx_level !== 0) begin n_err++; $display("FAIL %s tx_level: got %0d want 0", tag, tx_level); end
        n_cmp++; if (rx_level !== 0) begin n_err++; $display("FAIL %s rx_level: got %0d want 0", tag, rx_level); end
        n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL %s tx_valid: got %b want 0", tag, tx_valid); end
        n_cmp++; if (host_tx_ready !== 1'b1) begin n_err++; $display("FAIL %s host_tx_ready: got %b want 1", tag, host_tx_ready); end
        n_cmp++; if (host_rx_valid !== 1'b0) begin n_err++; $display("FAIL %s host_rx_valid: got %b want 0", tag, host_rx_valid); end
        n_cmp++; if (rx_overflow !== 1'b0) begin n_err++; $display("FAIL %s rx_overflow: got %b want 0", tag, rx_overflow); end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        check_idle_state("reset");
        tq.delete(); rq.delete(); ovf_model = 1'b0;
    endtask

    task automatic test_tx_fill();
        tx_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            host_tx_valid = 1'b1; host_tx_data = 8'(i);
            step();
            if (i == 0) begin
                n_cmp++; if (tx_valid !== 1'b1) begin n_err++; $display("FAIL tx_latency: tx_valid got %b want 1", tx_valid); end
            end
        end
        n_cmp++; if (tx_level !== LW'(DEPTH)) begin n_err++; $display("FAIL tx_full level: got %0d want %0d", tx_level, DEPTH); end
        n_cmp++; if (host_tx_ready !== 1'b0) begin n_err++; $display("FAIL tx_full ready: got %b want 0", host_tx_ready); end
        host_tx_data = 8'h55;
        step();
        host_tx_valid = 1'b0;
        n_cmp++; if (tx_level !== LW'(DEPTH)) begin n_err++; $display("FAIL tx_17th level: got %0d want %0d", tx_level, DEPTH); end
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 8'(i)) begin
                n_err++; $display("FAIL tx_drain[%0d]: got valid=%b data=%02h want valid=1 data=%02h", i, tx_valid, tx_data, 8'(i));
            end
            tx_ready = 1'b1; step();
            tx_ready = 1'b0; step();
        end
        n_cmp++; if (tx_valid !== 1'b0 || tx_level !== 0) begin
            n_err++; $display("FAIL tx_drained: got valid=%b level=%0d want 0/0", tx_valid, tx_level);
        end
    endtask

    task automatic test_rx_basic();
        logic [7:0] exp_b;
        host_rx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rx_ready = 1'b1; rx_data = 8'h41 + 8'(i);
            step();
            rx_ready = 1'b0;
            if (i == 0) begin
                n_cmp++; if (host_rx_valid !== 1'b1) begin n_err++; $display("FAIL rx_latency: host_rx_valid got %b want 1", host_rx_valid); end
            end
        end
        n_cmp++; if (rx_level !== 3) begin n_err++; $display("FAIL rx_level3: got %0d want 3", rx_level); end
        for (int i = 0; i < 3; i++) begin
            exp_b = 8'h41 + 8'(i);
            n_cmp++; if (host_rx_valid !== 1'b1 || host_rx_data !== exp_b) begin
                n_err++; $display("FAIL rx_drain[%0d]: got valid=%b data=%02h want valid=1 data=%02h", i, host_rx_valid, host_rx_data, exp_b);
            end
            host_rx_ready = 1'b1; step(); host_rx_ready = 1'b0;
        end
        n_cmp++; if (host_rx_valid !== 1'b0) begin n_err++; $display("FAIL rx_empty: host_rx_valid got %b want 0", host_rx_valid); end
    endtask

    task automatic test_rx_overflow();
        logic [7:0] b;
        rq.delete();
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom);
            rx_ready = 1'b1; rx_data = b; rq.push_back(b);
            step();
        end
        rx_data = 8'h99;
        step();
        rx_ready = 1'b0;
        n_cmp++; if (rx_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", rx_overflow); end
        n_cmp++; if (rx_level !== LW'(DEPTH)) begin n_err++; $display("FAIL ovf_level: got %0d want %0d", rx_level, DEPTH); end
        rx_ready = 1'b1; rx_data = 8'hAA; host_rx_ready = 1'b1;
        void'(rq.pop_front()); rq.push_back(8'hAA);
        step();
        rx_ready = 1'b0; host_rx_ready = 1'b0;
        n_cmp++; if (rx_level !== LW'(DEPTH)) begin n_err++; $display("FAIL full_push_pop level: got %0d want %0d", rx_level, DEPTH); end
        rx_ready = 1'b1; rx_data = 8'h77; ovf_clr = 1'b1;
        step();
        rx_ready = 1'b0; ovf_clr = 1'b0;
        step();
        ovf_clr = 1'b1;
        n_cmp++; if (rx_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set_beats_clr: got %b want 1", rx_overflow); end
        step();
        ovf_clr = 1'b0;
        n_cmp++; if (rx_overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clr: got %b want 0", rx_overflow); end
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++; if (host_rx_valid !== 1'b1 || host_rx_data !== rq[0]) begin
                n_err++; $display("FAIL ovf_drain[%0d]: got valid=%b data=%02h want valid=1 data=%02h", i, host_rx_valid, host_rx_data, rq[0]);
            end
            void'(rq.pop_front());
            host_rx_ready = 1'b1; step(); host_rx_ready = 1'b0;
        end
        n_cmp++; if (host_rx_valid !== 1'b0) begin n_err++; $display("FAIL ovf_drained: host_rx_valid got %b want 0", host_rx_valid); end
    endtask

    task automatic test_tx_random();
        logic       hv, tr, last_acc, do_pop, do_push;
        logic [7:0] d;
        int         pushes;
        tq.delete(); last_acc = 1'b0; pushes = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            n_cmp++; if (tx_level !== LW'(tq.size()) || tx_valid !== (tq.size() != 0) || host_tx_ready !== (tq.size() != DEPTH)) begin
                n_err++; $display("FAIL txr_state cyc %0d: got level=%0d valid=%b ready=%b want level=%0d", cyc, tx_level, tx_valid, host_tx_ready, tq.size());
            end
            if (tq.size() != 0) begin
                n_cmp++; if (tx_data !== tq[0]) begin n_err++; $display("FAIL txr_data cyc %0d: got %02h want %02h", cyc, tx_data, tq[0]); end
            end
            hv = ($urandom_range(0, 3) != 0);
            d  = 8'($urandom);
            tr = last_acc ? 1'b0 : 1'($urandom_range(0, 1));
            host_tx_valid = hv; host_tx_data = d; tx_ready = tr;
            do_pop  = (tq.size() != 0) && tr;
            do_push = hv && (tq.size() < DEPTH);
            step();
            if (do_pop) void'(tq.pop_front());
            if (do_push) begin tq.push_back(d); pushes++; end
            last_acc = do_pop;
        end
        host_tx_valid = 1'b0;
        for (int cyc = 0; cyc < 4 * DEPTH && tq.size() != 0; cyc++) begin
            n_cmp++; if (tx_valid !== 1'b1 || tx_data !== tq[0]) begin
                n_err++; $display("FAIL txr_drain: got valid=%b data=%02h want valid=1 data=%02h", tx_valid, tx_data, tq[0]);
            end
            tx_ready = ~tx_ready;
            do_pop = tx_ready;
            step();
            if (do_pop) void'(tq.pop_front());
        end
        tx_ready = 1'b0;
        n_cmp++; if (tq.size() != 0 || tx_valid !== 1'b0 || pushes < 20) begin
            n_err++; $display("FAIL txr_end: model left=%0d tx_valid=%b pushes=%0d want 0/0/>=20", tq.size(), tx_valid, pushes);
        end
    endtask

    task automatic test_rx_random();
        logic       rr, hr, do_pop, do_push, drop;
        logic [7:0] d;
        rq.delete(); ovf_model = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            n_cmp++; if (rx_level !== LW'(rq.size()) || host_rx_valid !== (rq.size() != 0) || rx_overflow !== ovf_model) begin
                n_err++; $display("FAIL rxr_state cyc %0d: got level=%0d valid=%b ovf=%b want level=%0d ovf=%b",
                                  cyc, rx_level, host_rx_valid, rx_overflow, rq.size(), ovf_model);
            end
            if (rq.size() != 0) begin
                n_cmp++; if (host_rx_data !== rq[0]) begin n_err++; $display("FAIL rxr_data cyc %0d: got %02h want %02h", cyc, host_rx_data, rq[0]); end
            end
            rr = ($urandom_range(0, 3) != 0);
            hr = (cyc % 80 < 40) ? ($urandom_range(0, 4) == 0) : 1'($urandom_range(0, 1));
            d  = 8'($urandom);
            ovf_clr = ($urandom_range(0, 15) == 0);
            rx_ready = rr; rx_data = d; host_rx_ready = hr;
            do_pop  = hr && (rq.size() != 0);
            do_push = rr && ((rq.size() < DEPTH) || do_pop);
            drop    = rr && !do_push;
            step();
            if (do_pop) void'(rq.pop_front());
            if (do_push) rq.push_back(d);
            if (drop) ovf_model = 1'b1;
            else if (ovf_clr) ovf_model = 1'b0;
        end
        idle_inputs();
        rx_flush = 1'b1; rx_ready = 1'b1; rx_data = 8'h3C;
        step();
        idle_inputs();
        rq.delete(); ovf_model = 1'b0;
        n_cmp++; if (rx_level !== 0 || host_rx_valid !== 1'b0 || rx_overflow !== 1'b0) begin
            n_err++; $display("FAIL rx_flush: got level=%0d valid=%b ovf=%b want 0/0/0", rx_level, host_rx_valid, rx_overflow);
        end
    endtask

    task automatic test_async_reset();
        tx_ready = 1'b0; host_tx_valid = 1'b1; rx_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            host_tx_data = 8'($urandom); rx_data = 8'($urandom);
            step();
        end
        n_cmp++; if (tx_level !== 5 || rx_level !== 5) begin
            n_err++; $display("FAIL pre_reset levels: got tx=%0d rx=%0d want 5/5", tx_level, rx_level);
        end
        #2 rst = 1'b1;
        #1;
        check_idle_state("async_reset");
        idle_inputs();
        step();
        rst = 1'b0;
        tq.delete(); rq.delete(); ovf_model = 1'b0;
        step();
    endtask

    task automatic test_tx_flush();
        tx_ready = 1'b0; host_tx_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin host_tx_data = 8'h10 + 8'(i); step(); end
        host_tx_data = 8'hEE; tx_flush = 1'b1;
        step();
        tx_flush = 1'b0; host_tx_valid = 1'b0;
        n_cmp++; if (tx_level !== 0 || tx_valid !== 1'b0) begin
            n_err++; $display("FAIL tx_flush: got level=%0d valid=%b want 0/0", tx_level, tx_valid);
        end
        host_tx_valid = 1'b1; host_tx_data = 8'h5A;
        step();
        host_tx_valid = 1'b0;
        n_cmp++; if (tx_level !== 1 || tx_data !== 8'h5A) begin
            n_err++; $display("FAIL tx_after_flush: got level=%0d data=%02h want 1/5a", tx_level, tx_data);
        end
        tx_ready = 1'b1; step(); tx_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_tx_fill();
        test_rx_basic();
        test_rx_overflow();
        test_tx_random();
        test_rx_random();
        test_async_reset();
        test_tx_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
